cache_mem_port: RTL and testbench

//  Initiator side of the cache<->main-memory line protocol; owns m_read_i/m_wr_i/m_addr_i/m_wr_data_i.

---
 rtl/cache_mem_pkg.sv | 26 ++
 rtl/cache_mem_watchdog.sv | 30 +++
 rtl/cache_mem_port.sv | 184 ++++++++++++++++++
 tb/tb_cache_mem_port.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_pkg.sv
// cache_mem_pkg: shared state encoding and width helpers
// for the cache <-> main-memory line port.
package cache_mem_pkg;

  localparam int C_BLOCK_SIZE   = 2;
  localparam int C_LINE_SIZE    = 64;
  localparam int ADDRESS_SIZE   = 32;
  localparam int MEM_LINE_SIZE  = 32;
  localparam int TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } mem_state_e;

  function automatic int line_w(input int bs, input int ls);
    return (2 ** bs) * ls;
  endfunction

  function automatic int laddr_w(input int as, input int bs);
    return as - bs - 2;
  endfunction

endpackage

// File: rtl/cache_mem_watchdog.sv
// cache_mem_watchdog: counts cycles spent in one memory
// state and flags expiry on the last allowed cycle.
module cache_mem_watchdog #(
  parameter int limit = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(limit + 1);

  logic [CW-1:0] cnt_q;

  // cycle counter, restarted on every state entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || !en) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = en && (cnt_q == CW'(limit - 1));

endmodule

// File: rtl/cache_mem_port.sv
// cache_mem_port: miss handler, optional write-back then
// refill. Watchdog abort enabled by CACHE_MEM_TIMEOUT_EN.
module cache_mem_port
  import cache_mem_pkg::*;
#(
  parameter int c_block_size   = C_BLOCK_SIZE,
  parameter int c_line_size    = C_LINE_SIZE,
  parameter int address_size   = ADDRESS_SIZE,
  parameter int mem_line_size  = MEM_LINE_SIZE,
  parameter int timeout_cycles = TIMEOUT_CYCLES,
  localparam int LW =
    line_w(c_block_size, c_line_size),
  localparam int LA =
    laddr_w(address_size, c_block_size)
) (
  input  logic          c_clk_i,
  input  logic          c_reset_n_i,
  input  logic          c_req_i,
  input  logic          c_dirty_i,
  input  logic [LA-1:0] c_fill_addr_i,
  input  logic [LA-1:0] c_wb_addr_i,
  input  logic [LW-1:0] c_wb_data_i,
  output logic          c_busy_o,
  output logic [LW-1:0] c_fill_data_o,
  output logic          c_fill_valid_o,
  output logic          c_err_o,
  output logic          m_read_i,
  output logic          m_wr_i,
  output logic [LA-1:0] m_addr_i,
  output logic [LW-1:0] m_wr_data_i,
  input  logic          m_busywait_o,
  input  logic [LW-1:0] m_read_data_o,
  input  logic          m_read_done,
  input  logic          m_write_done
);

  // memory serialises beats itself; busywait is status only
  localparam int unused_beats = LW / mem_line_size;
  localparam int unused_tmo   = timeout_cycles;
  logic unused_bw;
  assign unused_bw = m_busywait_o;

  mem_state_e    state_q, state_d;
  logic          busy_q, busy_d;
  logic          fv_q, fv_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [LA-1:0] addr_q, addr_d;
  logic [LA-1:0] fa_q, fa_d;
  logic [LW-1:0] wd_q, wd_d;
  logic [LW-1:0] fd_q, fd_d;
  logic          wd_exp;

`ifdef CACHE_MEM_TIMEOUT_EN
  logic err_q, err_d;

  cache_mem_watchdog #(
    .limit(timeout_cycles)
  ) u_wd (
    .clk    (c_clk_i),
    .rst_n  (c_reset_n_i),
    .en     ((state_q == S_WB) ||
             (state_q == S_FILL)),
    .clear  (state_d != state_q),
    .expired(wd_exp)
  );

  // error pulse register
  always_ff @(posedge c_clk_i or negedge c_reset_n_i) begin
    if (!c_reset_n_i) err_q <= 1'b0;
    else              err_q <= err_d;
  end

  assign c_err_o = err_q;
`else
  assign wd_exp  = 1'b0;
  assign c_err_o = 1'b0;
`endif

  // next state and next registered outputs
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    fv_d    = 1'b0;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    fa_d    = fa_q;
    wd_d    = wd_q;
    fd_d    = fd_q;
`ifdef CACHE_MEM_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (c_req_i) begin
          busy_d = 1'b1;
          fa_d   = c_fill_addr_i;
          if (c_dirty_i) begin
            state_d = S_WB;
            wr_d    = 1'b1;
            addr_d  = c_wb_addr_i;
            wd_d    = c_wb_data_i;
          end else begin
            state_d = S_FILL;
            rd_d    = 1'b1;
            addr_d  = c_fill_addr_i;
          end
        end
      end
      S_WB: begin
        if (m_write_done) begin
          wr_d    = 1'b0;
          rd_d    = 1'b1;
          addr_d  = fa_q;
          state_d = S_FILL;
        end else if (wd_exp) begin
          wr_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
`ifdef CACHE_MEM_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end
      end
      S_FILL: begin
        if (m_read_done) begin
          fd_d    = m_read_data_o;
          rd_d    = 1'b0;
          fv_d    = 1'b1;
          state_d = S_DONE;
        end else if (wd_exp) begin
          rd_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
`ifdef CACHE_MEM_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge c_clk_i or negedge c_reset_n_i) begin
    if (!c_reset_n_i) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      fv_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      fa_q    <= '0;
      wd_q    <= '0;
      fd_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      fv_q    <= fv_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      fa_q    <= fa_d;
      wd_q    <= wd_d;
      fd_q    <= fd_d;
    end
  end

  assign c_busy_o       = busy_q;
  assign c_fill_valid_o = fv_q;
  assign c_fill_data_o  = fd_q;
  assign m_read_i       = rd_q;
  assign m_wr_i         = wr_q;
  assign m_addr_i       = addr_q;
  assign m_wr_data_i    = wd_q;

endmodule

// File: tb/tb_cache_mem_port.sv
// tb_cache_mem_port: scoreboard bench with a 6-cycle
// memory model for the cache line port.
module tb_cache_mem_port;

  localparam int LW = 256;
  localparam int LA = 28;

  typedef struct {
    logic [LA-1:0] a;
    logic [LW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          c_req = 1'b0;
  logic          c_dirty = 1'b0;
  logic [LA-1:0] c_fa = '0;
  logic [LA-1:0] c_wa = '0;
  logic [LW-1:0] c_wd = '0;
  logic          c_busy;
  logic [LW-1:0] c_fd;
  logic          c_fv;
  logic          c_err;
  logic          m_rd;
  logic          m_wr;
  logic [LA-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  logic          m_bw = 1'b0;
  logic [LW-1:0] m_rdata = '0;
  logic          m_rdone = 1'b0;
  logic          m_wdone = 1'b0;

  cache_mem_port dut (
    .c_clk_i       (clk),
    .c_reset_n_i   (rst_n),
    .c_req_i       (c_req),
    .c_dirty_i     (c_dirty),
    .c_fill_addr_i (c_fa),
    .c_wb_addr_i   (c_wa),
    .c_wb_data_i   (c_wd),
    .c_busy_o      (c_busy),
    .c_fill_data_o (c_fd),
    .c_fill_valid_o(c_fv),
    .c_err_o       (c_err),
    .m_read_i      (m_rd),
    .m_wr_i        (m_wr),
    .m_addr_i      (m_addr),
    .m_wr_data_i   (m_wdata),
    .m_busywait_o  (m_bw),
    .m_read_data_o (m_rdata),
    .m_read_done   (m_rdone),
    .m_write_done  (m_wdone)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [LW-1:0] obs,
                     input logic [LW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  // memory model
  logic [LW-1:0] mem [logic [LA-1:0]];
  logic spur_rd = 1'b0;
  logic spur_wr = 1'b0;
  logic hang = 1'b0;
  int   mcnt = 0;

  function automatic logic [LW-1:0] rd_line(
    input logic [LA-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {8{4'h0, a}};
  endfunction

  always @(negedge clk) begin
    m_rdone = 1'b0;
    m_wdone = 1'b0;
    if (!rst_n) begin
      mcnt = 0;
    end else if ((m_rd || m_wr) && !hang) begin
      mcnt++;
      if (mcnt == 6) begin
        mcnt = 0;
        if (m_wr) begin
          mem[m_addr] = m_wdata;
          m_wdone = 1'b1;
        end else begin
          m_rdata = rd_line(m_addr);
          m_rdone = 1'b1;
        end
      end
    end else begin
      mcnt = 0;
    end
    if (spur_rd) begin
      m_rdata = '1;
      m_rdone = 1'b1;
    end
    if (spur_wr) m_wdone = 1'b1;
    m_bw = (m_rd || m_wr) && !(m_rdone || m_wdone);
  end

  // scoreboard
  wr_t           exp_wr[$];
  logic [LA-1:0] exp_rd[$];
  logic [LW-1:0] exp_fill[$];
  logic [LA-1:0] cur_rd = '0;
  logic p_rd = 1'b0;
  logic p_wr = 1'b0;
  logic p_fv = 1'b0;
  int   rd_rise = 0;
  int   wr_rise = 0;
  int   fv_cnt = 0;

  always @(posedge clk) begin
    wr_t e;
    #1;
    if (rst_n) begin
      if (m_rd && m_wr) chk("rd_wr_excl", 1, 0);
      if (m_wr && !p_wr) begin
        wr_rise++;
        if (exp_wr.size() == 0) begin
          chk("wr_unexp", 1, 0);
        end else begin
          e = exp_wr.pop_front();
          chk("wb_addr", m_addr, e.a);
          chk("wb_data", m_wdata, e.d);
        end
      end
      if (m_rd && !p_rd) begin
        rd_rise++;
        if (p_wr) chk("wb2fill_edge", m_wdone, 1);
        if (exp_rd.size() == 0) begin
          chk("rd_unexp", 1, 0);
        end else begin
          cur_rd = exp_rd.pop_front();
          chk("rd_addr", m_addr, cur_rd);
        end
      end else if (m_rd && m_addr != cur_rd) begin
        chk("rd_addr_hold", m_addr, cur_rd);
      end
      if (c_fv) begin
        fv_cnt++;
        chk("fv_pulse", p_fv, 0);
        chk("fill_lat", m_rdone, 1);
        if (exp_fill.size() == 0) begin
          chk("fill_unexp", 1, 0);
        end else begin
          chk("fill_data", c_fd, exp_fill.pop_front());
        end
      end
    end
    p_rd = m_rd;
    p_wr = m_wr;
    p_fv = c_fv;
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic miss(input logic dirty,
                      input logic [LA-1:0] fa,
                      input logic [LA-1:0] wa,
                      input logic [LW-1:0] wd);
    wr_t e;
    c_req   = 1'b1;
    c_dirty = dirty;
    c_fa    = fa;
    c_wa    = wa;
    c_wd    = wd;
    if (dirty) begin
      e.a = wa;
      e.d = wd;
      exp_wr.push_back(e);
    end
    exp_rd.push_back(fa);
    exp_fill.push_back(rd_line(fa));
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!c_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_idle"}, ok, 1);
  endtask

  logic [LW-1:0] dat;
  int b_rd, b_wr, b_fv;

  initial begin
    #2;
    chk("rst_busy", c_busy, 0);
    chk("rst_fv", c_fv, 0);
    chk("rst_err", c_err, 0);
    chk("rst_rd", m_rd, 0);
    chk("rst_wr", m_wr, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_wdata", m_wdata, 0);
    chk("rst_fdata", c_fd, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // clean miss
    mem[28'h12] = {32{8'hA5}};
    b_wr = wr_rise;
    b_fv = fv_cnt;
    miss(1'b0, 28'h12, 28'h0, '0);
    tick();
    c_req = 1'b0;
    chk("t1_rd", m_rd, 1);
    chk("t1_addr", m_addr, 28'h12);
    chk("t1_busy", c_busy, 1);
    wait_idle("t1");
    chk("t1_fv_cnt", fv_cnt - b_fv, 1);
    chk("t1_no_wr", wr_rise - b_wr, 0);
    chk("t1_hold", c_fd, {32{8'hA5}});

    // dirty miss
    dat = {4{64'hDEAD_C0DE_FACE_BEEF}};
    b_fv = fv_cnt;
    miss(1'b1, 28'h35, 28'h34, dat);
    tick();
    c_req = 1'b0;
    chk("t2_wr", m_wr, 1);
    chk("t2_rd", m_rd, 0);
    chk("t2_addr", m_addr, 28'h34);
    wait_idle("t2");
    chk("t2_fv_cnt", fv_cnt - b_fv, 1);
    chk("t2_mem", mem[28'h34], dat);

    // request held across a busy period
    b_rd = rd_rise;
    b_fv = fv_cnt;
    miss(1'b0, 28'hA1, 28'h0, '0);
    tick();
    c_fa = 28'hA2;
    exp_rd.push_back(28'hA2);
    exp_fill.push_back(rd_line(28'hA2));
    wait_idle("t3a");
    chk("t3_gap_rd", m_rd, 0);
    tick();
    c_req = 1'b0;
    chk("t3_busy2", c_busy, 1);
    wait_idle("t3b");
    chk("t3_rd_cnt", rd_rise - b_rd, 2);
    chk("t3_fv_cnt", fv_cnt - b_fv, 2);
    dat = c_fd;
    chk("t3_hold", dat, rd_line(28'hA2));

    // spurious dones in IDLE
    b_fv = fv_cnt;
    spur_rd = 1'b1;
    tick();
    spur_rd = 1'b0;
    spur_wr = 1'b1;
    tick();
    spur_wr = 1'b0;
    tick();
    chk("t4_busy", c_busy, 0);
    chk("t4_rd", m_rd, 0);
    chk("t4_wr", m_wr, 0);
    chk("t4_fv", fv_cnt - b_fv, 0);
    chk("t4_fdata", c_fd, rd_line(28'hA2));
    // spurious write done in FILL
    miss(1'b0, 28'h50, 28'h0, '0);
    tick();
    c_req = 1'b0;
    tick();
    spur_wr = 1'b1;
    tick();
    spur_wr = 1'b0;
    tick();
    chk("t4f_rd", m_rd, 1);
    chk("t4f_busy", c_busy, 1);
    chk("t4f_fv", fv_cnt - b_fv, 0);
    wait_idle("t4f");
    // spurious read done in WB
    miss(1'b1, 28'h61, 28'h60, {8{32'h1234_5678}});
    tick();
    c_req = 1'b0;
    tick();
    spur_rd = 1'b1;
    tick();
    spur_rd = 1'b0;
    tick();
    chk("t4w_wr", m_wr, 1);
    chk("t4w_rd", m_rd, 0);
    chk("t4w_fv", fv_cnt - b_fv, 1);
    wait_idle("t4w");
    chk("t4w_fv2", fv_cnt - b_fv, 2);

    // reset during FILL
    miss(1'b0, 28'h70, 28'h0, '0);
    tick();
    c_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rd", m_rd, 0);
    chk("t5_busy", c_busy, 0);
    chk("t5_addr", m_addr, 0);
    chk("t5_fdata", c_fd, 0);
    exp_fill.delete();
    exp_rd.delete();
    exp_wr.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    b_fv = fv_cnt;
    miss(1'b0, 28'h71, 28'h0, '0);
    tick();
    c_req = 1'b0;
    wait_idle("t5");
    chk("t5_fv_cnt", fv_cnt - b_fv, 1);

`ifdef CACHE_MEM_TIMEOUT_EN
    begin
      int n;
      bit seen;
      hang = 1'b1;
      b_fv = fv_cnt;
      c_req = 1'b1;
      c_dirty = 1'b0;
      c_fa = 28'h80;
      exp_rd.push_back(28'h80);
      tick();
      c_req = 1'b0;
      n = 0;
      seen = 1'b0;
      for (int i = 1; i < 200; i++) begin
        tick();
        if (c_err) begin
          n = i;
          seen = 1'b1;
          break;
        end
      end
      chk("t6_err_seen", seen, 1);
      chk("t6_err_cycle", n, 64);
      chk("t6_rd", m_rd, 0);
      chk("t6_busy", c_busy, 0);
      tick();
      chk("t6_err_pulse", c_err, 0);
      chk("t6_no_fv", fv_cnt - b_fv, 0);
      hang = 1'b0;
    end
`endif

    tick();
    chk("sb_fill_empty", exp_fill.size(), 0);
    chk("sb_rd_empty", exp_rd.size(), 0);
    chk("sb_wr_empty", exp_wr.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
